xif_coproc_scheduler: RTL and testbench

- Sequencer between the cv32e40x X-interface (issue/commit/result channels) and a multi-cycle custom execution unit (EXU).
- Accepts custom-opcode instructions and queues their operands in order.
- Dispatches an instruction to the EXU only after the core commits it; killed instructions are dropped.
- Returns EXU results to the core on the result channel.

---
 rtl/xif_coproc_scheduler.sv | 153 +++++++++++++++
 tb/tb_xif_coproc_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_coproc_scheduler.sv
// xif_coproc_scheduler: in-order X-interface sequencer feeding a multi-cycle EXU.
// Define XIF_SCHED_PERF_EN to add saturating accepted/killed/result counters.
module xif_coproc_scheduler #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ID_W   = 4,
    parameter logic [6:0]  OPCODE = 7'h42
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [31:0]     issue_instr_i,
    input  logic [ID_W-1:0] issue_id_i,
    input  logic [31:0]     issue_rs0_i,
    input  logic [31:0]     issue_rs1_i,
    input  logic [1:0]      issue_rs_valid_i,
    output logic            issue_accept_o,
    output logic            issue_writeback_o,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            exu_valid_o,
    input  logic            exu_ready_i,
    output logic [9:0]      exu_funct_o,
    output logic [31:0]     exu_op_a_o,
    output logic [31:0]     exu_op_b_o,
    input  logic            exu_done_i,
    input  logic [31:0]     exu_data_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic [4:0]      result_rd_o,
    output logic [31:0]     result_data_o,
    output logic            result_we_o
`ifdef XIF_SCHED_PERF_EN
    ,
    output logic [31:0]     perf_accepted_o,
    output logic [31:0]     perf_killed_o,
    output logic [31:0]     perf_results_o
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {E_FREE, E_PEND, E_COMMIT, E_KILL} ent_e;
    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_RESULT} state_e;

    ent_e            ent_q   [DEPTH];
    logic [ID_W-1:0] id_q    [DEPTH];
    logic [4:0]      rd_q    [DEPTH];
    logic [9:0]      funct_q [DEPTH];
    logic [31:0]     a_q     [DEPTH];
    logic [31:0]     b_q     [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    state_e          state_q, state_d;
    logic [31:0]     data_q;
    logic            full, push, pop, done, push_hit;
    ent_e            push_st;
    logic            unused_instr;

    assign unused_instr      = ^issue_instr_i[24:15];
    assign full              = count_q == CW'(DEPTH);
    assign issue_ready_o     = !full;
    assign issue_accept_o    = issue_valid_i && issue_instr_i[6:0] == OPCODE && issue_rs_valid_i == 2'b11 && !full;
    assign issue_writeback_o = issue_accept_o;
    assign push              = issue_accept_o;
    // A commit racing the push of its own id lands directly in the new entry.
    assign push_hit          = commit_valid_i && commit_id_i == issue_id_i;
    assign push_st           = !push_hit ? E_PEND : commit_kill_i ? E_KILL : E_COMMIT;
    assign done              = exu_done_i && (state_q == S_WAIT || (state_q == S_DISPATCH && exu_ready_i));

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = ent_q[head_q] == E_COMMIT ? S_DISPATCH : S_IDLE;
                pop     = ent_q[head_q] == E_KILL;
            end
            S_DISPATCH: state_d = !exu_ready_i ? S_DISPATCH : done ? S_RESULT : S_WAIT;
            S_WAIT:     state_d = done ? S_RESULT : S_WAIT;
            S_RESULT: begin
                state_d = result_ready_i ? S_IDLE : S_RESULT;
                pop     = result_ready_i;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    assign exu_valid_o    = state_q == S_DISPATCH;
    assign exu_funct_o    = exu_valid_o ? funct_q[head_q] : '0;
    assign exu_op_a_o     = exu_valid_o ? a_q[head_q] : '0;
    assign exu_op_b_o     = exu_valid_o ? b_q[head_q] : '0;
    assign result_valid_o = state_q == S_RESULT;
    assign result_id_o    = result_valid_o ? id_q[head_q] : '0;
    assign result_rd_o    = result_valid_o ? rd_q[head_q] : '0;
    assign result_data_o  = result_valid_o ? data_q : '0;
    assign result_we_o    = result_valid_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= E_FREE;
        end else begin
            state_q <= state_d;
            count_q <= count_q + CW'(push) - CW'(pop);
            if (push) tail_q <= tail_q + PW'(1);
            if (pop) head_q <= head_q + PW'(1);
            if (done) data_q <= exu_data_i;
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && ent_q[i] == E_PEND && id_q[i] == commit_id_i)
                    ent_q[i] <= commit_kill_i ? E_KILL : E_COMMIT;
                if (pop && head_q == PW'(i)) ent_q[i] <= E_FREE;
                if (push && tail_q == PW'(i)) ent_q[i] <= push_st;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[tail_q]    <= issue_id_i;
            rd_q[tail_q]    <= issue_instr_i[11:7];
            funct_q[tail_q] <= {issue_instr_i[31:25], issue_instr_i[14:12]};
            a_q[tail_q]     <= issue_rs0_i;
            b_q[tail_q]     <= issue_rs1_i;
        end
    end

`ifdef XIF_SCHED_PERF_EN
    logic [31:0] perf_acc_q, perf_kill_q, perf_res_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_acc_q  <= '0;
            perf_kill_q <= '0;
            perf_res_q  <= '0;
        end else begin
            if (push && perf_acc_q != '1) perf_acc_q <= perf_acc_q + 32'd1;
            if (pop && state_q == S_IDLE && perf_kill_q != '1) perf_kill_q <= perf_kill_q + 32'd1;
            if (pop && state_q == S_RESULT && perf_res_q != '1) perf_res_q <= perf_res_q + 32'd1;
        end
    end

    assign perf_accepted_o = perf_acc_q;
    assign perf_killed_o   = perf_kill_q;
    assign perf_results_o  = perf_res_q;
`endif
endmodule

// File: tb/tb_xif_coproc_scheduler.sv
// tb_xif_coproc_scheduler: directed and random traffic against an in-order
// transaction model of the scheduler, with the bench acting as core and EXU.
module tb_xif_coproc_scheduler;
    localparam int DEPTH = 4;

    logic        clk_i, rst_ni;
    logic        issue_valid_i, issue_ready_o, issue_accept_o, issue_writeback_o;
    logic [31:0] issue_instr_i, issue_rs0_i, issue_rs1_i;
    logic [3:0]  issue_id_i, commit_id_i, result_id_o;
    logic [1:0]  issue_rs_valid_i;
    logic        commit_valid_i, commit_kill_i;
    logic        exu_valid_o, exu_ready_i, exu_done_i;
    logic [9:0]  exu_funct_o;
    logic [31:0] exu_op_a_o, exu_op_b_o, exu_data_i;
    logic        result_valid_o, result_ready_i, result_we_o;
    logic [4:0]  result_rd_o;
    logic [31:0] result_data_o;

    xif_coproc_scheduler #(.DEPTH(DEPTH), .ID_W(4), .OPCODE(7'h42)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
        .issue_id_i(issue_id_i), .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
        .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .exu_valid_o(exu_valid_o), .exu_ready_i(exu_ready_i), .exu_funct_o(exu_funct_o),
        .exu_op_a_o(exu_op_a_o), .exu_op_b_o(exu_op_b_o), .exu_done_i(exu_done_i), .exu_data_i(exu_data_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
        .result_rd_o(result_rd_o), .result_data_o(result_data_o), .result_we_o(result_we_o)
    );

    always #5 clk_i = ~clk_i;

    // One model entry per accepted instruction, in issue order.
    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [9:0]  funct;
        logic [31:0] a, b;
        bit          committed, killed, dispatched, finished;
        int          kage;
    } ent_t;

    ent_t        mq[$];
    int          vectors = 0, errs = 0;
    int          exu_rdy_pct = 100, res_rdy_pct = 100, lat_min = 0, lat_max = 0;
    bit          exu_busy = 0, acc_seen = 0;
    int          exu_cnt = 0, n_disp = 0, n_res = 0;
    logic [31:0] exu_res, last_data;
    logic [3:0]  last_id, next_id;
    logic [4:0]  last_rd;
    bit          prev_exu_stall = 0, prev_res_stall = 0;
    logic [73:0] prev_exu;
    logic [41:0] prev_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_live();
        for (int i = 0; i < mq.size(); i++) if (!mq[i].killed) return i;
        return -1;
    endfunction

    function automatic int live_count();
        int n = 0;
        for (int i = 0; i < mq.size(); i++) if (!mq[i].killed) n++;
        return n;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] v = $urandom;
        v[6:0] = 7'h42;
        return v;
    endfunction

    // One clock cycle: drive EXU/result handshakes, check outputs, update the model.
    task automatic step();
        int f, hi, lo, lat;
        bit elig;
        while (mq.size() > 0 && mq[0].killed && mq[0].kage >= 2) mq.delete(0);
        exu_done_i = 1'b0;
        if (exu_busy) begin
            if (exu_cnt == 0) begin
                exu_done_i = 1'b1;
                exu_data_i = exu_res;
                exu_busy = 0;
                f = first_live();
                if (f >= 0) mq[f].finished = 1;
            end else exu_cnt--;
        end
        exu_ready_i = !exu_busy && $urandom_range(99) < exu_rdy_pct;
        result_ready_i = $urandom_range(99) < res_rdy_pct;
        #1;
        hi = mq.size();
        lo = live_count();
        elig = issue_valid_i && issue_instr_i[6:0] == 7'h42 && issue_rs_valid_i == 2'b11;
        if (hi < DEPTH) chk("issue_ready", 32'(issue_ready_o), 32'd1);
        else if (lo >= DEPTH) chk("issue_ready_full", 32'(issue_ready_o), 32'd0);
        if (!elig) chk("accept_reject", 32'(issue_accept_o), 32'd0);
        else if (hi < DEPTH) chk("accept", 32'(issue_accept_o), 32'd1);
        else if (lo >= DEPTH) chk("accept_full", 32'(issue_accept_o), 32'd0);
        if (issue_valid_i) chk("writeback", 32'(issue_writeback_o), 32'(issue_accept_o));
        if (prev_exu_stall) begin
            chk("exu_hold_valid", 32'(exu_valid_o), 32'd1);
            chk("exu_hold_data", 32'({exu_funct_o, exu_op_a_o, exu_op_b_o} === prev_exu), 32'd1);
        end
        if (prev_res_stall) begin
            chk("res_hold_valid", 32'(result_valid_o), 32'd1);
            chk("res_hold_data", 32'({result_id_o, result_rd_o, result_data_o, result_we_o} === prev_res), 32'd1);
        end
        prev_exu_stall = exu_valid_o && !exu_ready_i;
        prev_exu = {exu_funct_o, exu_op_a_o, exu_op_b_o};
        prev_res_stall = result_valid_o && !result_ready_i;
        prev_res = {result_id_o, result_rd_o, result_data_o, result_we_o};
        acc_seen = issue_accept_o;
        if (issue_accept_o) begin
            ent_t e;
            e.id = issue_id_i; e.rd = issue_instr_i[11:7];
            e.funct = {issue_instr_i[31:25], issue_instr_i[14:12]};
            e.a = issue_rs0_i; e.b = issue_rs1_i;
            e.committed = 0; e.killed = 0; e.dispatched = 0; e.finished = 0; e.kage = 0;
            mq.push_back(e);
        end
        if (commit_valid_i)
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].id == commit_id_i && !mq[i].committed && !mq[i].killed) begin
                    if (commit_kill_i) mq[i].killed = 1;
                    else mq[i].committed = 1;
                end
        if (exu_valid_o && exu_ready_i) begin
            n_disp++;
            f = first_live();
            if (f < 0) chk("dispatch_unexpected", 32'd1, 32'd0);
            else begin
                chk("dispatch_single", 32'(mq[f].dispatched), 32'd0);
                chk("dispatch_committed", 32'(mq[f].committed), 32'd1);
                chk("exu_funct", 32'(exu_funct_o), 32'(mq[f].funct));
                chk("exu_op_a", exu_op_a_o, mq[f].a);
                chk("exu_op_b", exu_op_b_o, mq[f].b);
                mq[f].dispatched = 1;
            end
            exu_res = exu_op_a_o + exu_op_b_o + 32'(exu_funct_o);
            lat = int'($urandom_range(lat_max, lat_min));
            if (lat == 0) begin
                exu_done_i = 1'b1;
                exu_data_i = exu_res;
                if (f >= 0) mq[f].finished = 1;
            end else begin
                exu_busy = 1;
                exu_cnt = lat - 1;
            end
        end
        if (result_valid_o && result_ready_i) begin
            n_res++;
            last_id = result_id_o; last_rd = result_rd_o; last_data = result_data_o;
            chk("result_we", 32'(result_we_o), 32'd1);
            f = first_live();
            if (f < 0) chk("result_unexpected", 32'd1, 32'd0);
            else begin
                chk("result_finished", 32'(mq[f].finished), 32'd1);
                chk("result_id", 32'(result_id_o), 32'(mq[f].id));
                chk("result_rd", 32'(result_rd_o), 32'(mq[f].rd));
                chk("result_data", result_data_o, mq[f].a + mq[f].b + 32'(mq[f].funct));
                for (int j = 0; j <= f; j++) mq.delete(0);
            end
        end
        if (mq.size() > 0 && mq[0].killed) mq[0].kage++;
        @(negedge clk_i);
        issue_valid_i = 0;
        commit_valid_i = 0;
    endtask

    task automatic issue(input logic [3:0] id, input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        issue_valid_i = 1; issue_id_i = id; issue_instr_i = instr;
        issue_rs0_i = a; issue_rs1_i = b; issue_rs_valid_i = 2'b11;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1; commit_id_i = id; commit_kill_i = kill;
    endtask

    task automatic wait_results(input int target);
        int b = 0;
        while (n_res < target && b < 50) begin step(); b++; end
        chk("result_timeout", 32'(n_res >= target), 32'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_issue_ready", 32'(issue_ready_o), 32'd1);
        chk("rst_accept", 32'(issue_accept_o), 32'd0);
        chk("rst_exu_valid", 32'(exu_valid_o), 32'd0);
        chk("rst_exu_data", 32'({exu_funct_o, exu_op_a_o, exu_op_b_o} === 74'd0), 32'd1);
        chk("rst_result_valid", 32'(result_valid_o), 32'd0);
        chk("rst_result_data", 32'({result_id_o, result_rd_o, result_data_o, result_we_o} === 42'd0), 32'd1);
    endtask

    initial begin
        int cyc, d0, r0;
        clk_i = 0; rst_ni = 1;
        issue_valid_i = 0; issue_instr_i = 0; issue_id_i = 0; issue_rs0_i = 0; issue_rs1_i = 0;
        issue_rs_valid_i = 0; commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
        exu_ready_i = 0; exu_done_i = 0; exu_data_i = 0; result_ready_i = 0;
        #1 rst_ni = 0;
        repeat (2) @(negedge clk_i);
        check_reset_outputs();
        rst_ni = 1;
        @(negedge clk_i);

        // Basic transaction, zero-latency EXU: 7 + 9 = 16, rd 5, 3-cycle commit-to-result.
        issue(3, 32'h0000_02C2, 7, 9);
        step();
        chk("t1_accept", 32'(acc_seen), 32'd1);
        commit(3, 0);
        step();
        cyc = 1;
        while (!result_valid_o && cyc < 20) begin step(); cyc++; end
        chk("t1_latency", 32'(cyc), 32'd3);
        step();
        chk("t1_nres", 32'(n_res), 32'd1);
        chk("t1_id", 32'(last_id), 32'd3);
        chk("t1_rd", 32'(last_rd), 32'd5);
        chk("t1_data", last_data, 32'd16);

        // Foreign opcode is not claimed.
        issue(0, 32'h0000_0033, 1, 2);
        step();
        chk("t2_accept", 32'(acc_seen), 32'd0);

        // Fill to DEPTH, then a fifth issue bounces until a result pops.
        for (int i = 0; i < DEPTH; i++) begin
            issue(4'(i), rand_instr(), $urandom, $urandom);
            step();
            chk("t3_fill_accept", 32'(acc_seen), 32'd1);
        end
        chk("t3_full_ready", 32'(issue_ready_o), 32'd0);
        issue(4, rand_instr(), 1, 1);
        step();
        chk("t3_fifth_accept", 32'(acc_seen), 32'd0);
        commit(0, 0);
        step();
        wait_results(2);
        chk("t3_ready_after_pop", 32'(issue_ready_o), 32'd1);

        // Kill 1, commit 2, kill 3: one result (id 2), one EXU request.
        d0 = n_disp; r0 = n_res;
        commit(1, 1); step();
        commit(2, 0); step();
        commit(3, 1); step();
        wait_results(r0 + 1);
        repeat (6) step();
        chk("t4_results", 32'(n_res - r0), 32'd1);
        chk("t4_dispatches", 32'(n_disp - d0), 32'd1);
        chk("t4_id", 32'(last_id), 32'd2);

        // Backpressured result stays stable and blocks further dispatch.
        issue(4, rand_instr(), $urandom, $urandom);
        step();
        commit(4, 0);
        res_rdy_pct = 0;
        step();
        cyc = 0;
        while (!result_valid_o && cyc < 20) begin step(); cyc++; end
        d0 = n_disp; r0 = n_res;
        repeat (5) begin
            step();
            chk("t5_hold_valid", 32'(result_valid_o), 32'd1);
        end
        chk("t5_no_dispatch", 32'(n_disp), 32'(d0));
        res_rdy_pct = 100;
        step();
        chk("t5_id", 32'(last_id), 32'd4);
        chk("t5_nres", 32'(n_res), 32'(r0 + 1));

        // Commit/kill arriving in the same cycle as the issue of that id.
        d0 = n_disp; r0 = n_res;
        issue(5, rand_instr(), $urandom, $urandom);
        commit(5, 0);
        step();
        wait_results(r0 + 1);
        chk("t6_id", 32'(last_id), 32'd5);
        issue(6, rand_instr(), $urandom, $urandom);
        commit(6, 1);
        step();
        issue(7, rand_instr(), $urandom, $urandom);
        commit(7, 0);
        step();
        wait_results(r0 + 2);
        chk("t6_kill_id", 32'(last_id), 32'd7);
        chk("t6_dispatches", 32'(n_disp - d0), 32'd2);

        // Reset while the EXU is busy.
        lat_min = 6; lat_max = 6;
        issue(8, rand_instr(), $urandom, $urandom);
        step();
        commit(8, 0);
        d0 = n_disp;
        step();
        cyc = 0;
        while (n_disp == d0 && cyc < 20) begin step(); cyc++; end
        step();
        rst_ni = 0;
        #1;
        check_reset_outputs();
        mq.delete();
        exu_busy = 0; exu_done_i = 0; prev_exu_stall = 0; prev_res_stall = 0;
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
        chk("t7_ready_after_rst", 32'(issue_ready_o), 32'd1);

        // Random traffic with random EXU latency and back-pressure.
        lat_min = 0; lat_max = 3; exu_rdy_pct = 70; res_rdy_pct = 60;
        next_id = 9;
        for (int n = 0; n < 3000; n++) begin
            int p;
            p = -1;
            if ($urandom_range(99) < 60) begin
                issue(next_id, $urandom, $urandom, $urandom);
                if ($urandom_range(99) < 85) issue_instr_i[6:0] = 7'h42;
                if ($urandom_range(99) < 10) issue_rs_valid_i = 2'($urandom_range(2));
            end
            for (int i = 0; i < mq.size(); i++) if (p < 0 && !mq[i].committed && !mq[i].killed) p = i;
            if (p >= 0 && $urandom_range(99) < 40) commit(mq[p].id, $urandom_range(99) < 25);
            else if ($urandom_range(99) < 5) commit(next_id + 4'd8, 1'($urandom_range(1)));
            step();
            if (acc_seen) next_id++;
        end

        // Drain: commit everything outstanding and let all results return.
        exu_rdy_pct = 100; res_rdy_pct = 100;
        cyc = 0;
        while (live_count() > 0 && cyc < 500) begin
            for (int i = 0; i < mq.size(); i++)
                if (!commit_valid_i && !mq[i].committed && !mq[i].killed) commit(mq[i].id, 0);
            step();
            cyc++;
        end
        chk("drain_live", 32'(live_count()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
